biu_mem_sequencer: RTL and testbench
====================================

# biu_mem_sequencer

Sequencer for the bus interface unit's data-memory side. Accepts one memory command at a time (32/64-bit load, 32/64-bit store, 64-bit push, 64-bit pop). For each command it drives the BIU register controls (MAR, WrBuf, RdBuf, SP, address mux) and the data-memory strobes as one or two 32-bit bus cycles. It handles memory wait states through a ready handshake and aborts with an error on timeout. It sits between the execution control unit and the BIU.

## Interface
- WAIT_MAX, 15: max wait cycles per bus access before timeout (1..255).
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  3  command: 000 LD32, 001 LD64, 010 ST32, 011 ST64, 100 PUSH64, 101 POP64; 11x reserved.
- dM_rdy  in  1  memory ready; completes the current access.
- busy  out  1  high from the cycle after accept through DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout/illegal-op flag.
- MAR_ld, MAR_inc  out  1 each  MAR controls.
- WrBuf1_ld, WrBuf0_ld, WrBuf1_oe, WrBuf0_oe  out  1 each  write-buffer controls.
- RdBuf1_ld, RdBuf0_ld, Rdmux1, Rdmux0  out  1 each  read-buffer controls; Rdmux always 0 (Bus_data).
- dMem_addr_sel  out  1  0 = MAR, 1 = SP.
- SP_inc, SP_dec  out  1 each  stack-pointer controls.
- dM_cs, dM_rd, dM_wr  out  1 each  data-memory strobes.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high (Clk, Reset).
- States: IDLE, SETUP, ACC1, ADV, ACC2, FIN, DONE. All outputs are decoded from the registered state, latched op, and dM_rdy (RdBuf_ld only).
- Accept: IDLE && start. The op is latched. A reserved op goes directly to DONE with err=1.
- SETUP:
  - Loads, stores: MAR_ld=1.
  - Stores: also WrBuf1_ld=1 (ST64) and WrBuf0_ld=1 (ST32/ST64).
  - PUSH64: WrBuf1_ld=WrBuf0_ld=1, SP_dec=1.
  - POP64: no action.
- ACC1/ACC2:
  - dM_cs=1. Loads and POP: dM_rd=1. Stores and PUSH: dM_wr=1.
  - dMem_addr_sel=1 for PUSH/POP, else 0.
  - Stay until dM_rdy=1, then exit on the same edge.
- Word order, 64-bit: high word at address A, low word at A+1.
  - LD64/ST64: ACC1 moves the high word (RdBuf1 / WrBuf1_oe), ADV asserts MAR_inc, ACC2 moves the low word.
  - 32-bit ops: ACC1 only, using word 0 (RdBuf0_ld / WrBuf0_oe). ACC1 then goes to DONE.
- RdBuf*_ld = ACCn && dM_rdy && read-op, so data is captured on the completing edge.
- WrBuf*_oe is held for the whole ACC state.
- PUSH64:
  - SETUP SP_dec.
  - ACC1 writes the high word at SP-1.
  - ADV SP_dec.
  - ACC2 writes the low word at SP-2.
  - ACC2 goes to DONE. Net SP change is -2.
- POP64:
  - ACC1 reads the low word at SP into RdBuf0.
  - ADV SP_inc.
  - ACC2 reads the high word into RdBuf1.
  - FIN SP_inc.
  - FIN goes to DONE. Net SP change is +2.
- Wait counter:
  - Clears on entry to each ACC and increments each ACC cycle with dM_rdy=0.
  - When it reaches WAIT_MAX with dM_rdy still 0, go to DONE with err=1. Strobes drop and no further MAR/SP adjustment occurs.
  - A partially completed 64-bit op leaves the earlier word and SP/MAR changes in place.
- DONE: done=1, busy=1, then IDLE.
- err is set with done and holds until the next accepted start clears it.
- start while busy is ignored and not queued.
- dM_rdy outside ACC is ignored.

## Timing
- Reset (async) forces IDLE. All outputs are 0, including busy, done, err, and the wait counter.
- Reset mid-operation aborts immediately; strobes deassert without waiting for a clock.
- Accept edge T. SETUP is cycle T+1.
- Latency to done with zero wait states (dM_rdy=1):
  - LD32/ST32: T+3.
  - LD64/ST64/PUSH64: T+5.
  - POP64: T+6.
- Each wait cycle adds 1 per access.
- Timeout: done is asserted WAIT_MAX+1 cycles after ACC entry.
- Back-to-back: a start in the cycle after DONE (IDLE) is accepted. Minimum op-to-op spacing is latency+1.

## Test plan
- LD32, dM_rdy=1 constant, op=000 at T → MAR_ld at T+1; dM_cs/dM_rd and RdBuf0_ld at T+2; done at T+3; err=0; all other controls 0.
- ST64 with 2 wait cycles in ACC1 and 0 in ACC2 → WrBuf1_oe high 3 cycles, then MAR_inc 1 cycle, WrBuf0_oe 1 cycle; done at T+7.
- PUSH64 then POP64, memory model with SP=0x100 → writes at 0xFF (high) and 0xFE (low); POP returns the same 64-bit value into RdBuf; final SP=0x100.
- WAIT_MAX=3, LD64 with dM_rdy stuck 0 → ACC1 lasts 4 cycles; done with err=1; no MAR_inc; RdBuf*_ld never asserted; next start clears err.
- Reset asserted during ACC2 of ST64 → all outputs 0 asynchronously; IDLE after release; a new LD32 completes normally.
- start pulsed while busy, and op=110 → extra start ignored; reserved op gives done+err at T+1 with no strobes.

Source files
------------

// File: rtl/biu_mem_sequencer_if.sv
// Bundle of handshake and control signals between the execution control unit /
// data memory side (master) and the BIU data-memory sequencer (slave).
//   start, op, dM_rdy : command strobe, command code, memory ready (to sequencer)
//   busy, done, err   : sequencer status
//   MAR_*, WrBuf*_*, RdBuf*_ld, Rdmux*, dMem_addr_sel, SP_* : BIU register controls
//   dM_cs, dM_rd, dM_wr : data-memory strobes
interface biu_mem_sequencer_if;
    logic       start;
    logic [2:0] op;
    logic       dM_rdy;
    logic       busy;
    logic       done;
    logic       err;
    logic       MAR_ld;
    logic       MAR_inc;
    logic       WrBuf1_ld;
    logic       WrBuf0_ld;
    logic       WrBuf1_oe;
    logic       WrBuf0_oe;
    logic       RdBuf1_ld;
    logic       RdBuf0_ld;
    logic       Rdmux1;
    logic       Rdmux0;
    logic       dMem_addr_sel;
    logic       SP_inc;
    logic       SP_dec;
    logic       dM_cs;
    logic       dM_rd;
    logic       dM_wr;

    modport master (
        output start, op, dM_rdy,
        input  busy, done, err, MAR_ld, MAR_inc, WrBuf1_ld, WrBuf0_ld,
               WrBuf1_oe, WrBuf0_oe, RdBuf1_ld, RdBuf0_ld, Rdmux1, Rdmux0,
               dMem_addr_sel, SP_inc, SP_dec, dM_cs, dM_rd, dM_wr
    );

    modport slave (
        input  start, op, dM_rdy,
        output busy, done, err, MAR_ld, MAR_inc, WrBuf1_ld, WrBuf0_ld,
               WrBuf1_oe, WrBuf0_oe, RdBuf1_ld, RdBuf0_ld, Rdmux1, Rdmux0,
               dMem_addr_sel, SP_inc, SP_dec, dM_cs, dM_rd, dM_wr
    );
endinterface

// File: rtl/biu_mem_sequencer.sv
// Data-memory sequencer of the bus interface unit. Runs one memory command
// (LD32/LD64/ST32/ST64/PUSH64/POP64) as one or two 32-bit bus accesses,
// stepping MAR/SP and the read/write buffers, with wait-state handling and a
// per-access timeout.
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous, active-high reset
//   bus   : slave side of biu_mem_sequencer_if (command in, controls/strobes out)
// Parameter:
//   WAIT_MAX : wait cycles allowed per access before timeout (1..255)
module biu_mem_sequencer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    biu_mem_sequencer_if.slave bus
);
    localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);
    localparam logic [2:0] OP_LD32 = 3'b000;
    localparam logic [2:0] OP_LD64 = 3'b001;
    localparam logic [2:0] OP_ST32 = 3'b010;
    localparam logic [2:0] OP_ST64 = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ACC1  = 3'd2,
        S_ADV   = 3'd3,
        S_ACC2  = 3'd4,
        S_FIN   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       err_q, err_d;
    logic [7:0] wcnt_q, wcnt_d;

    // Command class decode of the latched op
    logic is_ld32_s, is_ld64_s, is_st32_s, is_st64_s, is_push_s, is_pop_s;
    logic is_read_s, is_write_s, is_32_s, is_mar_op_s, timeout_s, hi_word_s;

    assign is_ld32_s   = (op_q == OP_LD32);
    assign is_ld64_s   = (op_q == OP_LD64);
    assign is_st32_s   = (op_q == OP_ST32);
    assign is_st64_s   = (op_q == OP_ST64);
    assign is_push_s   = (op_q == OP_PUSH);
    assign is_pop_s    = (op_q == OP_POP);
    assign is_read_s   = is_ld32_s | is_ld64_s | is_pop_s;
    assign is_write_s  = is_st32_s | is_st64_s | is_push_s;
    assign is_32_s     = is_ld32_s | is_st32_s;
    assign is_mar_op_s = is_ld32_s | is_ld64_s | is_st32_s | is_st64_s;
    assign timeout_s   = (wcnt_q == WAIT_MAX_C);
    // ACC1 moves the high word for LD64/ST64/PUSH; POP reads low first, so its
    // ACC2 carries the high word. 32-bit ops only ever use word 0.
    assign hi_word_s   = (state_q == S_ACC1) ? (is_ld64_s | is_st64_s | is_push_s) : is_pop_s;

    // State, latched op, error flag and wait counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            err_q   <= 1'b0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state, op latch, error and wait-counter update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d = bus.op;
                    if (bus.op[2:1] == 2'b11) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        err_d   = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_ACC1;
                wcnt_d  = 8'd0;
            end
            S_ACC1: begin
                if (bus.dM_rdy) begin
                    state_d = is_32_s ? S_DONE : S_ADV;
                end else if (timeout_s) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_ADV: begin
                state_d = S_ACC2;
                wcnt_d  = 8'd0;
            end
            S_ACC2: begin
                if (bus.dM_rdy) begin
                    state_d = is_pop_s ? S_FIN : S_DONE;
                end else if (timeout_s) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic mar_ld_s, mar_inc_s, wb1_ld_s, wb0_ld_s, wb1_oe_s, wb0_oe_s;
    logic rb1_ld_s, rb0_ld_s, asel_s, sp_inc_s, sp_dec_s, cs_s, rd_s, wr_s, done_s;

    // Control and strobe decode from the registered state (RdBuf loads also use dM_rdy)
    always_comb begin
        mar_ld_s  = 1'b0;
        mar_inc_s = 1'b0;
        wb1_ld_s  = 1'b0;
        wb0_ld_s  = 1'b0;
        wb1_oe_s  = 1'b0;
        wb0_oe_s  = 1'b0;
        rb1_ld_s  = 1'b0;
        rb0_ld_s  = 1'b0;
        asel_s    = 1'b0;
        sp_inc_s  = 1'b0;
        sp_dec_s  = 1'b0;
        cs_s      = 1'b0;
        rd_s      = 1'b0;
        wr_s      = 1'b0;
        done_s    = 1'b0;
        case (state_q)
            S_SETUP: begin
                mar_ld_s = is_mar_op_s;
                wb1_ld_s = is_st64_s | is_push_s;
                wb0_ld_s = is_st32_s | is_st64_s | is_push_s;
                sp_dec_s = is_push_s;
            end
            S_ACC1, S_ACC2: begin
                cs_s     = 1'b1;
                rd_s     = is_read_s;
                wr_s     = is_write_s;
                asel_s   = is_push_s | is_pop_s;
                wb1_oe_s = is_write_s & hi_word_s;
                wb0_oe_s = is_write_s & ~hi_word_s;
                rb1_ld_s = is_read_s & hi_word_s & bus.dM_rdy;
                rb0_ld_s = is_read_s & ~hi_word_s & bus.dM_rdy;
            end
            S_ADV: begin
                mar_inc_s = is_ld64_s | is_st64_s;
                sp_dec_s  = is_push_s;
                sp_inc_s  = is_pop_s;
            end
            S_FIN:   sp_inc_s = 1'b1;
            S_DONE:  done_s   = 1'b1;
            default: done_s   = 1'b0;
        endcase
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_s;
    assign bus.err           = err_q;
    assign bus.MAR_ld        = mar_ld_s;
    assign bus.MAR_inc       = mar_inc_s;
    assign bus.WrBuf1_ld     = wb1_ld_s;
    assign bus.WrBuf0_ld     = wb0_ld_s;
    assign bus.WrBuf1_oe     = wb1_oe_s;
    assign bus.WrBuf0_oe     = wb0_oe_s;
    assign bus.RdBuf1_ld     = rb1_ld_s;
    assign bus.RdBuf0_ld     = rb0_ld_s;
    // Read buffers always take Bus_data
    assign bus.Rdmux1        = 1'b0;
    assign bus.Rdmux0        = 1'b0;
    assign bus.dMem_addr_sel = asel_s;
    assign bus.SP_inc        = sp_inc_s;
    assign bus.SP_dec        = sp_dec_s;
    assign bus.dM_cs         = cs_s;
    assign bus.dM_rd         = rd_s;
    assign bus.dM_wr         = wr_s;
endmodule

// File: tb/tb_biu_mem_sequencer.sv
// Testbench for biu_mem_sequencer: models the BIU registers and a 512-word
// data memory driven by the sequencer's controls, and compares the results
// against an op-level reference model (latency, error, memory, MAR, SP, buffers).
module tb_biu_mem_sequencer;
    localparam int WM = 3;
    localparam logic [2:0] OP_LD32 = 3'b000;
    localparam logic [2:0] OP_LD64 = 3'b001;
    localparam logic [2:0] OP_ST32 = 3'b010;
    localparam logic [2:0] OP_ST64 = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;

    logic Clk;
    logic Reset;
    logic mem_init;
    biu_mem_sequencer_if bus();

    biu_mem_sequencer #(.WAIT_MAX(WM)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // BIU datapath environment
    logic [31:0] mem [0:511];
    logic [15:0] mar, sp, addr_in, cur_addr;
    logic [31:0] wb1, wb0, rb1, rb0, data_hi, data_lo;

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E3779B9 * 32'(i + 1) ^ 32'h5A5A0000;
    endfunction

    assign cur_addr = bus.dMem_addr_sel ? sp : mar;

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
            sp <= 16'h0100; mar <= 16'h0000;
            rb1 <= 32'h0; rb0 <= 32'h0; wb1 <= 32'h0; wb0 <= 32'h0;
        end else begin
            if (bus.MAR_ld) mar <= addr_in;
            else if (bus.MAR_inc) mar <= mar + 16'd1;
            if (bus.WrBuf1_ld) wb1 <= data_hi;
            if (bus.WrBuf0_ld) wb0 <= data_lo;
            if (bus.SP_dec) sp <= sp - 16'd1;
            else if (bus.SP_inc) sp <= sp + 16'd1;
            if (bus.dM_cs && bus.dM_wr && bus.dM_rdy)
                mem[cur_addr[8:0]] <= bus.WrBuf1_oe ? wb1 : wb0;
            if (bus.RdBuf1_ld) rb1 <= mem[cur_addr[8:0]];
            if (bus.RdBuf0_ld) rb0 <= mem[cur_addr[8:0]];
        end
    end

    // Reference state and per-op expectations
    logic [31:0] exp_mem [0:511];
    logic [15:0] exp_sp, exp_mar;
    logic [31:0] exp_rb1, exp_rb0;
    int e_lat, e_cs, e_rdld, e_marinc;
    bit e_err;

    int checks, failures;
    logic [18:0] trace [0:15];
    int cnt_wr1oe, cnt_wr0oe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [18:0] pack_out();
        return {bus.busy, bus.done, bus.err, bus.MAR_ld, bus.MAR_inc, bus.WrBuf1_ld,
                bus.WrBuf0_ld, bus.WrBuf1_oe, bus.WrBuf0_oe, bus.RdBuf1_ld, bus.RdBuf0_ld,
                bus.Rdmux1, bus.Rdmux0, bus.dMem_addr_sel, bus.SP_inc, bus.SP_dec,
                bus.dM_cs, bus.dM_rd, bus.dM_wr};
    endfunction

    // Op-level semantics: what each command does to memory, MAR, SP, buffers
    task automatic model_op(input logic [2:0] o, input logic [15:0] a, input logic [31:0] hi,
                            input logic [31:0] lo, input int w1, input int w2,
                            input bit s1, input bit s2);
        bit two, a1, a2;
        two = !(o == OP_LD32 || o == OP_ST32);
        a1 = !s1;
        a2 = two && a1 && !s2;
        e_rdld = 0; e_marinc = 0;
        if (o[2:1] == 2'b11) begin
            e_lat = 1; e_err = 1'b1; e_cs = 0;
        end else begin
            e_cs = a1 ? w1 + 1 : WM + 1;
            if (a1 && two) e_cs += a2 ? w2 + 1 : WM + 1;
            e_lat = 2 + e_cs + ((a1 && two) ? 1 : 0) + ((a2 && o == OP_POP) ? 1 : 0);
            e_err = !a1 || (two && !a2);
            case (o)
                OP_LD32: begin
                    exp_mar = a;
                    if (a1) begin exp_rb0 = exp_mem[a[8:0]]; e_rdld = 1; end
                end
                OP_ST32: begin
                    exp_mar = a;
                    if (a1) exp_mem[a[8:0]] = lo;
                end
                OP_LD64: begin
                    exp_mar = a;
                    if (a1) begin exp_rb1 = exp_mem[a[8:0]]; exp_mar = a + 16'd1; e_marinc = 1; e_rdld = 1; end
                    if (a2) begin exp_rb0 = exp_mem[exp_mar[8:0]]; e_rdld = 2; end
                end
                OP_ST64: begin
                    exp_mar = a;
                    if (a1) begin exp_mem[a[8:0]] = hi; exp_mar = a + 16'd1; e_marinc = 1; end
                    if (a2) exp_mem[exp_mar[8:0]] = lo;
                end
                OP_PUSH: begin
                    exp_sp = exp_sp - 16'd1;
                    if (a1) begin exp_mem[exp_sp[8:0]] = hi; exp_sp = exp_sp - 16'd1; end
                    if (a2) exp_mem[exp_sp[8:0]] = lo;
                end
                default: begin
                    if (a1) begin exp_rb0 = exp_mem[exp_sp[8:0]]; e_rdld = 1; exp_sp = exp_sp + 16'd1; end
                    if (a2) begin exp_rb1 = exp_mem[exp_sp[8:0]]; e_rdld = 2; exp_sp = exp_sp + 16'd1; end
                end
            endcase
        end
    endtask

    // Issue one command from IDLE (called at a falling edge) and check it
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [31:0] hi,
                          input logic [31:0] lo, input int w1, input int w2,
                          input bit s1, input bit s2, input bit xs);
        int k, acc, w, wt, cnt_busy, cnt_cs, cnt_rdld, cnt_marinc, cnt_bad;
        bit done_seen, prev_cs, st;
        logic [18:0] pk;
        logic err_k1, err_done;
        model_op(o, a, hi, lo, w1, w2, s1, s2);
        addr_in = a; data_hi = hi; data_lo = lo;
        bus.start = 1'b1; bus.op = o; bus.dM_rdy = 1'($urandom);
        @(posedge Clk); #1;
        bus.start = 1'b0; bus.op = 3'($urandom);
        k = 0; acc = 0; w = 0; done_seen = 1'b0; prev_cs = 1'b0;
        cnt_busy = 0; cnt_cs = 0; cnt_rdld = 0; cnt_marinc = 0; cnt_bad = 0;
        cnt_wr1oe = 0; cnt_wr0oe = 0; err_k1 = 1'b0; err_done = 1'b0;
        while (!done_seen && k < 64) begin
            @(negedge Clk);
            k++;
            if (xs) bus.start = (k == 2);
            if (bus.dM_cs && !prev_cs) begin acc++; w = 0; end
            prev_cs = bus.dM_cs;
            if (bus.dM_cs) begin
                wt = (acc == 1) ? w1 : w2;
                st = (acc == 1) ? s1 : s2;
                bus.dM_rdy = !st && (w >= wt);
                w++;
            end else begin
                bus.dM_rdy = 1'($urandom);
            end
            #1;
            pk = pack_out();
            if (k < 16) trace[k] = pk;
            if (k == 1) err_k1 = pk[16];
            cnt_busy   += int'(pk[18]);
            cnt_cs     += int'(pk[2]);
            cnt_rdld   += int'(pk[9] | pk[8]);
            cnt_marinc += int'(pk[14]);
            cnt_wr1oe  += int'(pk[11]);
            cnt_wr0oe  += int'(pk[10]);
            cnt_bad    += int'(pk[7] | pk[6] | (pk[1] & pk[0]) | (!pk[2] & (pk[1] | pk[0])) | (pk[4] & pk[3]));
            if (pk[17]) begin done_seen = 1'b1; err_done = pk[16]; end
        end
        bus.start = 1'b0;
        check("done_seen", 32'(done_seen), 32'd1);
        check("latency", 32'(k), 32'(e_lat));
        check("err_at_accept", 32'(err_k1), 32'(o[2:1] == 2'b11));
        check("err_at_done", 32'(err_done), 32'(e_err));
        check("busy_cycles", 32'(cnt_busy), 32'(e_lat));
        check("cs_cycles", 32'(cnt_cs), 32'(e_cs));
        check("rdbuf_loads", 32'(cnt_rdld), 32'(e_rdld));
        check("mar_inc", 32'(cnt_marinc), 32'(e_marinc));
        check("illegal_ctl", 32'(cnt_bad), 32'd0);
        @(negedge Clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("err_hold", 32'(bus.err), 32'(e_err));
        check("sp", 32'(sp), 32'(exp_sp));
        check("mar", 32'(mar), 32'(exp_mar));
        check("rdbuf1", rb1, exp_rb1);
        check("rdbuf0", rb0, exp_rb0);
    endtask

    initial begin
        int nbad;
        checks = 0; failures = 0;
        Reset = 1'b1; mem_init = 1'b1;
        bus.start = 1'b0; bus.op = 3'b000; bus.dM_rdy = 1'b0;
        addr_in = 16'h0; data_hi = 32'h0; data_lo = 32'h0;
        for (int i = 0; i < 512; i++) exp_mem[i] = init_word(i);
        exp_sp = 16'h0100; exp_mar = 16'h0; exp_rb1 = 32'h0; exp_rb0 = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_outputs", 32'(pack_out()), 32'd0);
        mem_init = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // LD32, zero waits: exact per-cycle controls
        run_op(OP_LD32, 16'h0010, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("ld32_setup", 32'(trace[1]), 32'h48000);
        check("ld32_acc1", 32'(trace[2]), 32'h40106);
        check("ld32_done", 32'(trace[3]), 32'h60000);

        // ST64, two waits in ACC1
        run_op(OP_ST64, 16'h0020, 32'h11112222, 32'h33334444, 2, 0, 1'b0, 1'b0, 1'b0);
        check("st64_setup", 32'(trace[1]), 32'h4B000);
        check("st64_wr1oe", 32'(cnt_wr1oe), 32'd3);
        check("st64_wr0oe", 32'(cnt_wr0oe), 32'd1);
        check("st64_lat", 32'(e_lat), 32'd7);

        // PUSH64 then POP64 around SP=0x100
        run_op(OP_PUSH, 16'h0, 32'hDEADBEEF, 32'h01234567, 0, 0, 1'b0, 1'b0, 1'b0);
        check("push_setup", 32'(trace[1]), 32'h43008);
        check("push_hi_ff", mem[9'h0FF], 32'hDEADBEEF);
        check("push_lo_fe", mem[9'h0FE], 32'h01234567);
        check("push_sp", 32'(sp), 32'h00FE);
        run_op(OP_POP, 16'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("pop_hi", rb1, 32'hDEADBEEF);
        check("pop_lo", rb0, 32'h01234567);
        check("pop_sp", 32'(sp), 32'h0100);

        // LD64 timeout in ACC1, then a normal op clears err
        run_op(OP_LD64, 16'h0030, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0, 1'b0);
        check("timeout_lat", 32'(e_lat), 32'd6);
        run_op(OP_LD32, 16'h0031, 32'h0, 32'h0, 1, 0, 1'b0, 1'b0, 1'b0);

        // Reserved op with an extra start while busy, and extra start on a normal op
        run_op(3'b110, 16'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("reserved_trace", 32'(trace[1]), 32'h70000);
        run_op(OP_ST32, 16'h0044, 32'h0, 32'hA5A5A5A5, 1, 0, 1'b0, 1'b0, 1'b1);

        // Reset during ACC2 of ST64
        addr_in = 16'h0040; data_hi = 32'hCAFEF00D; data_lo = 32'h5555AAAA;
        bus.start = 1'b1; bus.op = OP_ST64; bus.dM_rdy = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge Clk);
        #1;
        check("acc2_wr_before_reset", 32'({bus.dM_cs, bus.dM_wr, bus.WrBuf0_oe}), 32'h7);
        Reset = 1'b1;
        #1;
        check("reset_async", 32'(pack_out()), 32'd0);
        exp_mem[9'h040] = 32'hCAFEF00D; exp_mar = 16'h0041;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        run_op(OP_LD32, 16'h0041, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("after_reset_mem", mem[9'h040], 32'hCAFEF00D);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), 16'($urandom_range(0, 510)), $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0));
        end

        nbad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== exp_mem[i]) nbad++;
        check("mem_final", 32'(nbad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
